// File: rtl/jellyvl_cdc_level_filter.sv
// rtl/jellyvl_cdc_level_filter.sv - glitch filter and edge detector for a synchronized single-bit level
//
// Purpose: takes the already-synchronized level from a single-bit CDC synchronizer,
// commits a change only after FILTER_CYCLES consecutive cke edges sample the new
// value, and emits one-cycle rise/fall pulses on each committed change.
//
// Ports:
//   clk          destination-domain clock
//   reset        synchronous, active-high reset
//   cke          clock enable; 0 holds every register (including pulses)
//   in_level     synchronized input level
//   out_level    filtered level
//   out_rise     one-cycle pulse on a committed 0->1 change
//   out_fall     one-cycle pulse on a committed 1->0 change
//   glitch_count saturating count of rejected glitches
//
// Optional feature: define JELLYVL_CDC_LEVEL_FILTER_GLITCH_COUNT_EN to build the
// glitch counter; otherwise glitch_count is tied to zero.

module jellyvl_cdc_level_filter #(
    parameter int FILTER_CYCLES    = 4,
    parameter bit INIT_LEVEL       = 1'b0,
    parameter int GLITCH_CNT_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cke,
    input  logic                        in_level,
    output logic                        out_level,
    output logic                        out_rise,
    output logic                        out_fall,
    output logic [GLITCH_CNT_WIDTH-1:0] glitch_count
);

    generate
        if (FILTER_CYCLES < 1) begin : g_param_check
            $error("jellyvl_cdc_level_filter: FILTER_CYCLES must be >= 1");
        end
    endgenerate

    localparam int CNT_W = (FILTER_CYCLES < 1) ? 1 : $clog2(FILTER_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

    localparam logic [0:0] STABLE = 1'b0;
    localparam logic [0:0] PEND   = 1'b1;

    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;

    logic differ;
    logic commit;
    logic glitch;

    assign differ = (in_level != out_level);

    // With FILTER_CYCLES==1 there is no pending phase: the first differing
    // sample commits straight from STABLE.
    assign commit = differ &&
                    (((state == STABLE) && (FILTER_CYCLES == 1)) ||
                     ((state == PEND) && (cnt == CNT_LAST)));

    // The input fell back to the committed level before the change was accepted.
    assign glitch = (state == PEND) && !differ;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= STABLE;
            cnt       <= '0;
            out_level <= INIT_LEVEL;
            out_rise  <= 1'b0;
            out_fall  <= 1'b0;
        end else if (cke) begin
            out_rise <= commit && in_level;
            out_fall <= commit && !in_level;
            if (commit) begin
                out_level <= in_level;
                state     <= STABLE;
                cnt       <= '0;
            end else if (glitch) begin
                state <= STABLE;
                cnt   <= '0;
            end else if ((state == STABLE) && differ) begin
                state <= PEND;
                cnt   <= CNT_W'(1);
            end else if (state == PEND) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

`ifdef JELLYVL_CDC_LEVEL_FILTER_GLITCH_COUNT_EN
    logic [GLITCH_CNT_WIDTH-1:0] glitch_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            glitch_cnt <= '0;
        end else if (cke && glitch && (glitch_cnt != '1)) begin
            glitch_cnt <= glitch_cnt + GLITCH_CNT_WIDTH'(1);
        end
    end

    assign glitch_count = glitch_cnt;
`else
    assign glitch_count = '0;
`endif

endmodule

// File: tb/tb_jellyvl_cdc_level_filter.sv
// tb/tb_jellyvl_cdc_level_filter.sv - scoreboard bench for jellyvl_cdc_level_filter

module tb_jellyvl_cdc_level_filter;

`ifdef JELLYVL_CDC_LEVEL_FILTER_GLITCH_COUNT_EN
    localparam bit GC_EN = 1'b1;
`else
    localparam bit GC_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: FILTER_CYCLES=4
    logic       reset_a = 1'b1, cke_a = 1'b1, in_a = 1'b0;
    logic       level_a, rise_a, fall_a;
    logic [1:0] gc_a;

    // DUT B: FILTER_CYCLES=1 (bypass)
    logic       reset_b = 1'b1, cke_b = 1'b1, in_b = 1'b0;
    logic       level_b, rise_b, fall_b;
    logic [1:0] gc_b;

    jellyvl_cdc_level_filter #(
        .FILTER_CYCLES(4), .INIT_LEVEL(1'b0), .GLITCH_CNT_WIDTH(2)
    ) dut_a (
        .clk(clk), .reset(reset_a), .cke(cke_a), .in_level(in_a),
        .out_level(level_a), .out_rise(rise_a), .out_fall(fall_a), .glitch_count(gc_a)
    );

    jellyvl_cdc_level_filter #(
        .FILTER_CYCLES(1), .INIT_LEVEL(1'b0), .GLITCH_CNT_WIDTH(2)
    ) dut_b (
        .clk(clk), .reset(reset_b), .cke(cke_b), .in_level(in_b),
        .out_level(level_b), .out_rise(rise_b), .out_fall(fall_b), .glitch_count(gc_b)
    );

    typedef struct {
        string      tag;
        logic       la, ra, fa;
        logic [1:0] ga;
        logic       lb, rb, fb;
        logic [1:0] gb;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [1:0] eg(input int n);
        int s;
        s = (n > 3) ? 3 : n;
        return GC_EN ? 2'(s) : 2'd0;
    endfunction

    task automatic chk(input string tag, input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s.%s: got %0d expected %0d at %0t", tag, name, act, exp, $time);
        end
    endtask

    // Drive DUT A for one edge (DUT B held in reset), push the hand-derived result.
    task automatic stepa(input string tag, input logic r, input logic c, input logic i,
                         input logic el, input logic er, input logic ef, input logic [1:0] eg_a);
        exp_t e;
        @(negedge clk);
        reset_a = r; cke_a = c; in_a = i;
        reset_b = 1'b1; cke_b = 1'b1; in_b = 1'b0;
        e.tag = tag;
        e.la = el; e.ra = er; e.fa = ef; e.ga = eg_a;
        e.lb = 1'b0; e.rb = 1'b0; e.fb = 1'b0; e.gb = 2'd0;
        q.push_back(e);
    endtask

    // Drive DUT B for one edge (DUT A held in reset).
    task automatic stepb(input string tag, input logic r, input logic c, input logic i,
                         input logic el, input logic er, input logic ef, input logic [1:0] eg_b);
        exp_t e;
        @(negedge clk);
        reset_b = r; cke_b = c; in_b = i;
        reset_a = 1'b1; cke_a = 1'b1; in_a = 1'b0;
        e.tag = tag;
        e.la = 1'b0; e.ra = 1'b0; e.fa = 1'b0; e.ga = 2'd0;
        e.lb = el; e.rb = er; e.fb = ef; e.gb = eg_b;
        q.push_back(e);
    endtask

    // Monitor: outputs are valid every cycle, sampled 1 time unit after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk(e.tag, "level_a", int'(level_a), int'(e.la));
                chk(e.tag, "rise_a",  int'(rise_a),  int'(e.ra));
                chk(e.tag, "fall_a",  int'(fall_a),  int'(e.fa));
                chk(e.tag, "gc_a",    int'(gc_a),    int'(e.ga));
                chk(e.tag, "level_b", int'(level_b), int'(e.lb));
                chk(e.tag, "rise_b",  int'(rise_b),  int'(e.rb));
                chk(e.tag, "fall_b",  int'(fall_b),  int'(e.fb));
                chk(e.tag, "gc_b",    int'(gc_b),    int'(e.gb));
            end
        end
    end

    initial begin
        int wait_cycles;

        // reset state
        stepa("reset", 1, 1, 0, 0, 0, 0, 0);
        stepa("reset", 1, 1, 1, 0, 0, 0, 0);

        // level change: 1 held 10 edges, commit on the 4th
        for (int k = 1; k <= 10; k++) stepa("rise10", 0, 1, 1, k >= 4, k == 4, 0, 0);
        for (int k = 1; k <= 4; k++)  stepa("fall", 0, 1, 0, k < 4, 0, k == 4, 0);
        // back-to-back: reverse change right after a commit
        for (int k = 1; k <= 4; k++)  stepa("b2b_rise", 0, 1, 1, k == 4, k == 4, 0, 0);
        for (int k = 1; k <= 4; k++)  stepa("b2b_fall", 0, 1, 0, k < 4, 0, k == 4, 0);

        // glitches: 3 high edges then low; counter saturates at 3
        for (int g = 1; g <= 5; g++) begin
            for (int k = 1; k <= 3; k++) stepa("glitch_hi", 0, 1, 1, 0, 0, 0, eg(g - 1));
            stepa("glitch_lo", 0, 1, 0, 0, 0, 0, eg(g));
        end

        // reset mid-change discards the pending change
        stepa("rst_mid", 0, 1, 1, 0, 0, 0, eg(5));
        stepa("rst_mid", 0, 1, 1, 0, 0, 0, eg(5));
        stepa("rst_mid_rst", 1, 1, 1, 0, 0, 0, 0);
        for (int k = 1; k <= 5; k++) stepa("rst_mid_after", 0, 1, 1, k >= 4, k == 4, 0, 0);
        for (int k = 1; k <= 4; k++) stepa("rst_mid_fall", 0, 1, 0, k < 4, 0, k == 4, 0);

        // cke gating: 2 enabled edges, 5 held, 2 enabled -> commit
        stepa("cke_a", 0, 1, 1, 0, 0, 0, 0);
        stepa("cke_a", 0, 1, 1, 0, 0, 0, 0);
        for (int k = 1; k <= 5; k++) stepa("cke_hold", 0, 0, 1, 0, 0, 0, 0);
        stepa("cke_b", 0, 1, 1, 0, 0, 0, 0);
        stepa("cke_commit", 0, 1, 1, 1, 1, 0, 0);
        for (int k = 1; k <= 3; k++) stepa("cke_pulse_hold", 0, 0, 1, 1, 1, 0, 0);
        stepa("cke_pulse_clr", 0, 1, 1, 1, 0, 0, 0);
        // reset overrides cke=0
        stepa("rst_over_cke", 1, 0, 1, 0, 0, 0, 0);
        // a cke=0 edge is not a glitch exit; the next enabled edge is
        stepa("pend_cke", 0, 1, 1, 0, 0, 0, 0);
        stepa("pend_cke_hold", 0, 0, 0, 0, 0, 0, 0);
        stepa("pend_cke_glitch", 0, 1, 0, 0, 0, 0, eg(1));

        // bypass: FILTER_CYCLES=1, toggle every edge
        stepb("byp_reset", 1, 1, 0, 0, 0, 0, 0);
        stepb("byp_idle", 0, 1, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 6; k++) begin
            stepb("byp_toggle", 0, 1, k[0], k[0], k[0], !k[0], 0);
        end
        stepb("byp_steady", 0, 1, 0, 0, 0, 0, 0);

        wait_cycles = 0;
        while (q.size() > 0 && wait_cycles < 20) begin
            @(posedge clk);
            wait_cycles++;
        end
        @(posedge clk);
        #2;
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
